vector_len_stats: RTL and testbench

VECTOR_LEN_STATS -- requirements
Module: vector_len_stats

---
 rtl/vector_len_pkg.sv | 13 +
 rtl/vector_len_stats_hold.sv | 34 +++
 rtl/vector_len_stats.sv | 84 ++++++++
 tb/tb_vector_len_stats.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/vector_len_pkg.sv
// vector_len_pkg: shared length width, accumulator/holder states and result record
package vector_len_pkg;
  localparam int LEN_W_DEF = 29;
  localparam int SUM_W_MAX = LEN_W_DEF + 4;
  typedef enum logic {S_IDLE, S_ACC} acc_state_t;
  typedef enum logic {O_EMPTY, O_FULL} hold_state_t;
  // Fields sized for the widest supported configuration; narrower builds use the low bits.
  typedef struct packed {
    logic [LEN_W_DEF-1:0] min;
    logic [LEN_W_DEF-1:0] max;
    logic [SUM_W_MAX-1:0] sum;
  } result_t;
endpackage

// File: rtl/vector_len_stats_hold.sv
// vector_len_stats_hold: one-entry valid/ready result holder with sticky overrun
module vector_len_stats_hold
  import vector_len_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         out_valid,
  output logic         overrun
);
  hold_state_t st;
  assign out_valid = st == O_FULL;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= O_EMPTY;
      q <= '0;
      overrun <= 1'b0;
    end else if (load) begin
      if (st == O_EMPTY || out_ready) begin
        st <= O_FULL;
        q <= d;
      end else begin
        overrun <= 1'b1;
      end
    end else if (st == O_FULL && out_ready) begin
      st <= O_EMPTY;
    end
  end
endmodule

// File: rtl/vector_len_stats.sv
// vector_len_stats: windowed min/max/sum of length samples; VECTOR_LEN_STATS_MEAN_EN adds out_mean
module vector_len_stats
  import vector_len_pkg::*;
#(
  parameter int WIN_LOG2 = 2,
  parameter int LEN_W = LEN_W_DEF,
  localparam int SUM_W = LEN_W + WIN_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LEN_W-1:0] in_len,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [LEN_W-1:0] out_min,
  output logic [LEN_W-1:0] out_max,
  output logic [SUM_W-1:0] out_sum,
`ifdef VECTOR_LEN_STATS_MEAN_EN
  output logic [LEN_W-1:0] out_mean,
`endif
  output logic             overrun
);
  localparam int RW = $bits(result_t);
`ifdef VECTOR_LEN_STATS_MEAN_EN
  localparam int HW = RW + LEN_W;
`else
  localparam int HW = RW;
`endif
  acc_state_t st;
  logic [WIN_LOG2-1:0] cnt;
  logic [LEN_W-1:0] min_q, max_q, min_n, max_n;
  logic [SUM_W-1:0] sum_q, sum_n;
  logic done, unused;
  result_t res, q;
  logic [HW-1:0] d, hq;
  // In S_IDLE the next values simply load the sample, so one path covers both states.
  always_comb begin
    min_n = (st == S_IDLE || in_len < min_q) ? in_len : min_q;
    max_n = (st == S_IDLE || in_len > max_q) ? in_len : max_q;
    sum_n = (st == S_IDLE ? '0 : sum_q) + SUM_W'(in_len);
    done = in_valid && !flush && st == S_ACC && cnt == '1;
    res = '{min: LEN_W_DEF'(min_n), max: LEN_W_DEF'(max_n), sum: SUM_W_MAX'(sum_n)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      cnt <= '0;
      min_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (flush) begin
      st <= S_IDLE;
      cnt <= '0;
    end else if (in_valid) begin
      min_q <= min_n;
      max_q <= max_n;
      sum_q <= sum_n;
      cnt <= cnt + 1'b1;
      st <= done ? S_IDLE : S_ACC;
    end
  end
`ifdef VECTOR_LEN_STATS_MEAN_EN
  assign d = {LEN_W'(sum_n >> WIN_LOG2), res};
  assign {out_mean, q} = hq;
`else
  assign d = res;
  assign q = hq;
`endif
  vector_len_stats_hold #(.W(HW)) u_hold (
    .clk(clk),
    .rst(rst),
    .load(done),
    .d(d),
    .out_ready(out_ready),
    .q(hq),
    .out_valid(out_valid),
    .overrun(overrun)
  );
  assign out_min = q.min[LEN_W-1:0];
  assign out_max = q.max[LEN_W-1:0];
  assign out_sum = q.sum[SUM_W-1:0];
  assign unused = &{1'b0, q};
endmodule

// File: tb/tb_vector_len_stats.sv
// tb_vector_len_stats: directed checks of vector_len_stats (WIN=4, LEN_W=29)
module tb_vector_len_stats;
  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready, out_valid, overrun;
  logic [28:0] in_len, out_min, out_max, out_mean;
  logic [30:0] out_sum;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  vector_len_stats dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_len(in_len),
    .flush(flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_min(out_min),
    .out_max(out_max),
    .out_sum(out_sum),
`ifdef VECTOR_LEN_STATS_MEAN_EN
    .out_mean(out_mean),
`endif
    .overrun(overrun)
  );
`ifndef VECTOR_LEN_STATS_MEAN_EN
  assign out_mean = '0;
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic smp(input logic [28:0] l);
    in_valid = 1'b1;
    in_len = l;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_res(input string tag, input logic [28:0] mn, input logic [28:0] mx,
                         input logic [30:0] sm, input logic [28:0] mean);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".min"}, 64'(out_min), 64'(mn));
    chk({tag, ".max"}, 64'(out_max), 64'(mx));
    chk({tag, ".sum"}, 64'(out_sum), 64'(sm));
`ifdef VECTOR_LEN_STATS_MEAN_EN
    chk({tag, ".mean"}, 64'(out_mean), 64'(mean));
`endif
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".min"}, 64'(out_min), 64'd0);
    chk({tag, ".max"}, 64'(out_max), 64'd0);
    chk({tag, ".sum"}, 64'(out_sum), 64'd0);
    chk({tag, ".mean"}, 64'(out_mean), 64'd0);
    chk({tag, ".overrun"}, 64'(overrun), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_len = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");
    smp(3);
    smp(10);
    smp(7);
    chk("basic.pre", 64'(out_valid), 64'd0);
    smp(4);
    chk_res("basic", 3, 10, 24, 6);
    tick();
    chk("basic.consumed", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) smp(29'h1FFFFFFF);
    chk_res("max1", 29'h1FFFFFFF, 29'h1FFFFFFF, 31'h7FFFFFFC, 29'h1FFFFFFF);
    smp(29'h1FFFFFFF);
    chk("max.gap", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) smp(29'h1FFFFFFF);
    chk_res("max2", 29'h1FFFFFFF, 29'h1FFFFFFF, 31'h7FFFFFFC, 29'h1FFFFFFF);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) smp(1);
    chk_res("ovr.first", 1, 1, 4, 1);
    chk("ovr.flag0", 64'(overrun), 64'd0);
    for (int i = 0; i < 4; i++) smp(2);
    chk_res("ovr.held", 1, 1, 4, 1);
    chk("ovr.flag1", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("ovr.consumed", 64'(out_valid), 64'd0);
    chk("ovr.sticky", 64'(overrun), 64'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) smp(8);
    chk_res("rst.full", 8, 8, 32, 8);
    smp(1);
    smp(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst.mid");
    out_ready = 1'b1;
    smp(20);
    smp(30);
    smp(40);
    chk("rst.partial", 64'(out_valid), 64'd0);
    smp(50);
    chk_res("rst.clean", 20, 50, 140, 35);
    tick();
    smp(5);
    smp(6);
    flush = 1'b1;
    smp(9);
    flush = 1'b0;
    smp(1);
    smp(2);
    smp(3);
    chk("flush.partial", 64'(out_valid), 64'd0);
    smp(4);
    chk_res("flush", 1, 4, 10, 2);
    tick();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) smp(29'(i));
    smp(5);
    smp(6);
    smp(7);
    chk_res("same.held", 1, 4, 10, 2);
    out_ready = 1'b1;
    smp(8);
    chk_res("same.new", 5, 8, 26, 6);
    chk("same.overrun", 64'(overrun), 64'd0);
    tick();
    chk("same.drain", 64'(out_valid), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
